// File: rtl/query_row_double_buffer.sv
// Ping-pong query row buffer: one bank fills from the sender while the other is read.
// Define QRDB_STATUS_EN to expose the wr_bank_o / wr_count / rd_valid status outputs.
module query_row_double_buffer #(
   parameter int DATA_WIDTH = 11,
   parameter int ADDR_WIDTH = 7,
   parameter int DEPTH      = 128
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  fsm_enable,
   input  logic                  sender_enable,
   input  logic [DATA_WIDTH-1:0] sender_data,
   input  logic                  ren,
   input  logic [ADDR_WIDTH-1:0] radr,
   output logic [DATA_WIDTH-1:0] receiver_data
`ifdef QRDB_STATUS_EN
   ,
   output logic                  wr_bank_o,
   output logic [ADDR_WIDTH-1:0] wr_count,
   output logic                  rd_valid
`endif
);

   localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);
   localparam logic [ADDR_WIDTH:0]   DEPTH_EXT = (ADDR_WIDTH + 1)'(DEPTH);

   logic [DATA_WIDTH-1:0] bank0 [DEPTH];
   logic [DATA_WIDTH-1:0] bank1 [DEPTH];

   logic                  wr_bank;
   logic [ADDR_WIDTH-1:0] wr_addr;
   logic                  wr_en;
   logic                  wr_last;
   logic                  radr_oob;

   always_comb begin
      wr_en    = fsm_enable & sender_enable;
      wr_last  = (wr_addr == LAST_ADDR);
      radr_oob = ({1'b0, radr} >= DEPTH_EXT);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_addr <= '0;
         wr_bank <= 1'b0;
      end else if (wr_en) begin
         if (wr_last) begin
            wr_addr <= '0;
            wr_bank <= ~wr_bank;
         end else begin
            wr_addr <= wr_addr + ADDR_WIDTH'(1);
         end
      end
   end

   // Memory arrays carry no reset so they map onto plain RAM.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         if (wr_bank) begin
            bank1[wr_addr] <= sender_data;
         end else begin
            bank0[wr_addr] <= sender_data;
         end
      end
   end

   // Read bank is the one not being written; sampling the pre-edge wr_bank
   // makes a coincident swap take effect only from the following edge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         receiver_data <= '0;
      end else if (ren) begin
         if (radr_oob) begin
            receiver_data <= '0;
         end else if (wr_bank) begin
            receiver_data <= bank0[radr];
         end else begin
            receiver_data <= bank1[radr];
         end
      end
   end

`ifdef QRDB_STATUS_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_valid <= 1'b0;
      end else if (wr_en && wr_last) begin
         rd_valid <= 1'b1;
      end
   end

   always_comb begin
      wr_bank_o = wr_bank;
      wr_count  = wr_addr;
   end
`endif

endmodule

// File: tb/tb_query_row_double_buffer.sv
// Directed bench for query_row_double_buffer: reset, fill/swap, overlap, write gate, hold, swap boundary.
module tb_query_row_double_buffer;

   localparam int DW = 11;
   localparam int AW = 7;

   logic          clk;
   logic          rst_n;
   logic          fsm_enable;
   logic          sender_enable;
   logic [DW-1:0] sender_data;
   logic          ren;
   logic [AW-1:0] radr;
   logic [DW-1:0] receiver_data;
   logic [DW-1:0] d2_receiver_data;

   int checks;
   int errors;

`ifdef QRDB_STATUS_EN
   logic          wr_bank_o;
   logic [AW-1:0] wr_count;
   logic          rd_valid;
   logic          d2_wr_bank_o;
   logic [AW-1:0] d2_wr_count;
   logic          d2_rd_valid;
`endif

   query_row_double_buffer #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(128)) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .fsm_enable    (fsm_enable),
      .sender_enable (sender_enable),
      .sender_data   (sender_data),
      .ren           (ren),
      .radr          (radr),
      .receiver_data (receiver_data)
`ifdef QRDB_STATUS_EN
      ,
      .wr_bank_o     (wr_bank_o),
      .wr_count      (wr_count),
      .rd_valid      (rd_valid)
`endif
   );

   // Shallow instance so that addresses >= DEPTH are reachable.
   query_row_double_buffer #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(100)) dut2 (
      .clk           (clk),
      .rst_n         (rst_n),
      .fsm_enable    (fsm_enable),
      .sender_enable (sender_enable),
      .sender_data   (sender_data),
      .ren           (ren),
      .radr          (radr),
      .receiver_data (d2_receiver_data)
`ifdef QRDB_STATUS_EN
      ,
      .wr_bank_o     (d2_wr_bank_o),
      .wr_count      (d2_wr_count),
      .rd_valid      (d2_rd_valid)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   initial begin
      checks        = 0;
      errors        = 0;
      rst_n         = 1'b1;
      fsm_enable    = 1'b0;
      sender_enable = 1'b0;
      sender_data   = '0;
      ren           = 1'b0;
      radr          = '0;

      // Asynchronous reset, no clock edge in between
      #2 rst_n = 1'b0;
      #1 chk("reset_rd", 32'(receiver_data), 0);
      chk("reset_rd_d2", 32'(d2_receiver_data), 0);
      @(negedge clk) rst_n = 1'b1;

      // Partial fill, then reset discards it
      fsm_enable    = 1'b1;
      sender_enable = 1'b1;
      sender_data   = 11'd55; tick();
      sender_data   = 11'd66; tick();
      sender_data   = 11'd77; tick();
      sender_enable = 1'b0;
      rst_n = 1'b0;
      #3 rst_n = 1'b1;

      // Full fill: 7, 1..127 -> bank0, swap (dut2 wraps at 100)
      sender_enable = 1'b1;
      sender_data   = 11'd7; tick();
      for (int i = 1; i < 128; i++) begin
         sender_data = DW'(i);
         tick();
      end
      sender_enable = 1'b0;

      ren = 1'b1;
      radr = 7'd0;   tick(); chk("fill_rd0", 32'(receiver_data), 7);
      chk("fill_rd0_d2", 32'(d2_receiver_data), 7);
      radr = 7'd5;   tick(); chk("fill_rd5", 32'(receiver_data), 5);
      chk("fill_rd5_d2", 32'(d2_receiver_data), 5);
      radr = 7'd99;  tick(); chk("fill_rd99", 32'(receiver_data), 99);
      chk("fill_rd99_d2", 32'(d2_receiver_data), 99);
      radr = 7'd100; tick(); chk("fill_rd100", 32'(receiver_data), 100);
      chk("oob_rd100_d2", 32'(d2_receiver_data), 0);
      radr = 7'd127; tick(); chk("fill_rd127", 32'(receiver_data), 127);

      // Hold while ren=0
      radr = 7'd3; tick(); chk("hold_rd3", 32'(receiver_data), 3);
      ren  = 1'b0;
      radr = 7'd9; tick(); chk("hold_1", 32'(receiver_data), 3);
      tick();              chk("hold_2", 32'(receiver_data), 3);

      // Overlap: write 1000+i to bank1 while reading bank0
      for (int i = 0; i < 127; i++) begin
         sender_enable = 1'b1;
         sender_data   = DW'(1000 + i);
         ren           = 1'b1;
         radr          = AW'(i);
         tick();
         chk($sformatf("overlap_rd%0d", i), 32'(receiver_data), (i == 0) ? 32'd7 : 32'(i));
      end

      // Write gate: 10 cycles of sender_enable with fsm_enable low
      fsm_enable    = 1'b0;
      sender_enable = 1'b1;
      sender_data   = 11'd2000;
      ren           = 1'b0;
      repeat (10) tick();

      // 128th write coincident with a read: pre-swap bank returned
      fsm_enable  = 1'b1;
      sender_data = 11'd1127;
      ren         = 1'b1;
      radr        = 7'd0;
      tick(); chk("swap_rd_old", 32'(receiver_data), 7);
      sender_enable = 1'b0;
      radr = 7'd0;   tick(); chk("swap_rd_new0", 32'(receiver_data), 1000);
      radr = 7'd127; tick(); chk("gate_rd127", 32'(receiver_data), 1127);
      radr = 7'd126; tick(); chk("gate_rd126", 32'(receiver_data), 1126);

`ifdef QRDB_STATUS_EN
      chk("status_rd_valid", 32'(rd_valid), 1);
      chk("status_wr_bank", 32'(wr_bank_o), 0);
      chk("status_wr_count", 32'(wr_count), 0);
`endif

      // Asynchronous reset with non-zero read data
      ren = 1'b0;
      #2 rst_n = 1'b0;
      #1 chk("async_reset_rd", 32'(receiver_data), 0);
`ifdef QRDB_STATUS_EN
      chk("status_reset_rd_valid", 32'(rd_valid), 0);
`endif
      @(negedge clk) rst_n = 1'b1;
      tick();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
